// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU front-panel sequencer: key codes, FSM encoding,
// display blank code and WAIT timeout.
package alu_ctrl_pkg;

    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_SHOW  = 3'd4;

    localparam logic [4:0] BLANK   = 5'b10000;
    localparam logic [7:0] TIMEOUT = 8'd255;

    typedef enum logic [1:0] {TGT_A, TGT_B, TGT_OP} tgt_e;

    function automatic tgt_e key_to_tgt(input logic [3:0] key);
        case (key)
            KEY_B:   return TGT_B;
            KEY_C:   return TGT_OP;
            default: return TGT_A;
        endcase
    endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// Two-digit packed BCD to binary, purely combinational (max result 99).
module bcd2_to_bin (
    input  logic [7:0] i_bcd,
    output logic [6:0] o_bin
);

    logic [6:0] w_hi;
    logic [6:0] w_lo;

    assign w_hi  = {3'b000, i_bcd[7:4]};
    assign w_lo  = {3'b000, i_bcd[3:0]};
    assign o_bin = (w_hi << 3) + (w_hi << 1) + w_lo;

endmodule

// File: rtl/alu_sequencer.sv
// Keypad-driven operand entry and launch/wait sequencing for an external ALU,
// with a registered seven-segment nibble mux.
module alu_sequencer
    import alu_ctrl_pkg::*;
(
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [3:0] key_val,
    input  logic       key_stb,
    input  logic [2:0] rr,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] OpCode,
    output logic       alu_start,
    output logic       busy,
    output logic       err,
    output logic [4:0] digit_holder
);

    logic [2:0] r_state, w_state_nxt;
    tgt_e       r_tgt, w_tgt_nxt;
    logic [7:0] r_buf, w_buf_nxt;
    logic [7:0] r_res, w_res_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_a, w_a_nxt;
    logic [3:0] r_b, w_b_nxt;
    logic [3:0] r_op, w_op_nxt;
    logic       r_err, w_err_nxt;
    logic       r_start;
    logic       r_busy;
    logic [4:0] r_digit, w_digit_nxt;
    logic [6:0] w_bin;
    logic       w_is_digit;
    logic       w_is_sel;

    bcd2_to_bin u_bcd2_to_bin (
        .i_bcd (r_buf),
        .o_bin (w_bin)
    );

    assign w_is_digit = (key_val <= 4'd9);
    assign w_is_sel   = (key_val == KEY_A) || (key_val == KEY_B) || (key_val == KEY_C);

    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_buf_nxt   = r_buf;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE, ST_SHOW: begin
                if (key_stb) begin
                    if (w_is_sel) begin
                        w_state_nxt = ST_ENTRY;
                        w_tgt_nxt   = key_to_tgt(key_val);
                        w_buf_nxt   = 8'h00;
                        w_err_nxt   = 1'b0;
                    end else if (key_val == KEY_D) begin
                        w_state_nxt = ST_EXEC;
                    end else if (key_val == KEY_F) begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            ST_ENTRY: begin
                if (key_stb) begin
                    if (w_is_digit) begin
                        w_buf_nxt = {r_buf[3:0], key_val};
                    end else if (w_is_sel) begin
                        w_tgt_nxt = key_to_tgt(key_val);
                        w_buf_nxt = 8'h00;
                    end else if (key_val == KEY_F) begin
                        w_state_nxt = ST_IDLE;
                    end else if (key_val == KEY_E) begin
                        w_state_nxt = ST_IDLE;
                        // Out-of-range entries leave the target untouched and flag an error.
                        if (w_bin <= 7'd15) begin
                            w_err_nxt = 1'b0;
                            case (r_tgt)
                                TGT_A:   w_a_nxt  = w_bin[3:0];
                                TGT_B:   w_b_nxt  = w_bin[3:0];
                                TGT_OP:  w_op_nxt = w_bin[3:0];
                                default: ;
                            endcase
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = 8'd0;
            end
            ST_WAIT: begin
                // Completion beats a simultaneous abort key.
                if (alu_done) begin
                    w_res_nxt   = alu_result;
                    w_state_nxt = ST_SHOW;
                end else if (key_stb && (key_val == KEY_F)) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == TIMEOUT - 8'd1) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_digit_nxt = BLANK;
        case (rr)
            3'd0: w_digit_nxt = {2'b00, r_state};
            3'd1: w_digit_nxt = {4'b0000, r_err};
            3'd2: w_digit_nxt = {1'b0, r_op};
            3'd3: w_digit_nxt = {1'b0, r_a};
            3'd4: w_digit_nxt = {1'b0, r_b};
            3'd5: w_digit_nxt = BLANK;
            3'd6: w_digit_nxt = (r_state == ST_SHOW) ? {1'b0, r_res[7:4]} : {1'b0, r_buf[7:4]};
            3'd7: w_digit_nxt = (r_state == ST_SHOW) ? {1'b0, r_res[3:0]} : {1'b0, r_buf[3:0]};
            default: w_digit_nxt = BLANK;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= ST_IDLE;
            r_tgt   <= TGT_A;
            r_buf   <= 8'h00;
            r_res   <= 8'h00;
            r_cnt   <= 8'd0;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_op    <= 4'd0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_digit <= BLANK;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_buf   <= w_buf_nxt;
            r_res   <= w_res_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_err   <= w_err_nxt;
            r_start <= (w_state_nxt == ST_EXEC);
            r_busy  <= (w_state_nxt == ST_ENTRY) || (w_state_nxt == ST_EXEC) ||
                       (w_state_nxt == ST_WAIT);
            r_digit <= w_digit_nxt;
        end
    end

    assign A            = r_a;
    assign B            = r_b;
    assign OpCode       = r_op;
    assign alu_start    = r_start;
    assign busy         = r_busy;
    assign err          = r_err;
    assign digit_holder = r_digit;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a key-level behavioural model queues expected
// values; one negedge monitor checks launches and serves queued probes.
module tb_alu_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_SHOW  = 4;
    localparam int K_D = 13;
    localparam int K_E = 14;
    localparam int K_F = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_val = 4'd0;
    logic       key_stb = 1'b0;
    logic [2:0] rr = 3'd0;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'd0;
    logic [3:0] A, B, OpCode;
    logic       alu_start, busy, err;
    logic [4:0] digit_holder;

    alu_sequencer dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .key_val      (key_val),
        .key_stb      (key_stb),
        .rr           (rr),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .A            (A),
        .B            (B),
        .OpCode       (OpCode),
        .alu_start    (alu_start),
        .busy         (busy),
        .err          (err),
        .digit_holder (digit_holder)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    string pq_name[$];
    int pq_sel[$];
    int pq_exp[$];
    int probe_req = 0;
    int probe_ack = 0;
    logic [11:0] launch_q[$];
    int n_launch = 0;
    int last_run = 0;

    // Behavioural model, advanced per key / per operation
    int m_a, m_b, m_op, m_buf, m_res, m_err, m_state, m_tgt;
    int m_launch = 0;

    // Monitor: launches, busy run length, queued probes
    initial begin
        logic [11:0] exp_l;
        logic prev_start;
        int busy_cnt;
        int act;
        int sel;
        int expv;
        string nm;
        prev_start = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1) begin
                n_launch++;
                checks++;
                if (prev_start) begin
                    errors++;
                    $display("FAIL start_width: alu_start high on consecutive cycles, required one");
                end else if (launch_q.size() == 0) begin
                    errors++;
                    $display("FAIL launch: got unexpected alu_start, required none");
                end else begin
                    exp_l = launch_q.pop_front();
                    if ({A, B, OpCode} !== exp_l) begin
                        errors++;
                        $display("FAIL launch_operands: got %h required %h", {A, B, OpCode}, exp_l);
                    end
                end
            end
            prev_start = (alu_start === 1'b1);
            if (busy === 1'b1) busy_cnt++;
            else if (busy_cnt != 0) begin
                last_run = busy_cnt;
                busy_cnt = 0;
            end
            while (probe_ack != probe_req) begin
                nm = pq_name.pop_front();
                sel = pq_sel.pop_front();
                expv = pq_exp.pop_front();
                case (sel)
                    0: act = (^digit_holder === 1'bx) ? -1 : int'(digit_holder);
                    1: act = (^A === 1'bx) ? -1 : int'(A);
                    2: act = (^B === 1'bx) ? -1 : int'(B);
                    3: act = (^OpCode === 1'bx) ? -1 : int'(OpCode);
                    4: act = (err === 1'bx) ? -1 : int'(err);
                    5: act = (busy === 1'bx) ? -1 : int'(busy);
                    6: act = (alu_start === 1'bx) ? -1 : int'(alu_start);
                    7: act = last_run;
                    8: act = launch_q.size();
                    default: act = n_launch;
                endcase
                checks++;
                if (act != expv) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", nm, act, expv);
                end
                probe_ack++;
            end
        end
    end

    task automatic probe(input string nm, input int sel, input int expv);
        pq_name.push_back(nm);
        pq_sel.push_back(sel);
        pq_exp.push_back(expv);
        probe_req++;
        wait (probe_ack == probe_req);
    endtask

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_buf = 0; m_res = 0; m_err = 0;
        m_state = M_IDLE; m_tgt = 0;
    endfunction

    function automatic void model_key(input int k);
        int v;
        if (m_state == M_IDLE || m_state == M_SHOW) begin
            if (k >= 10 && k <= 12) begin
                m_state = M_ENTRY; m_tgt = k - 10; m_buf = 0; m_err = 0;
            end else if (k == K_F) begin
                m_state = M_IDLE; m_err = 0;
            end
        end else if (m_state == M_ENTRY) begin
            if (k <= 9) m_buf = (m_buf % 16) * 16 + k;
            else if (k >= 10 && k <= 12) begin
                m_tgt = k - 10; m_buf = 0;
            end else if (k == K_F) m_state = M_IDLE;
            else if (k == K_E) begin
                v = (m_buf / 16) * 10 + (m_buf % 16);
                if (v <= 15) begin
                    if (m_tgt == 0) m_a = v;
                    else if (m_tgt == 1) m_b = v;
                    else m_op = v;
                    m_err = 0;
                end else m_err = 1;
                m_state = M_IDLE;
            end
        end
    endfunction

    function automatic int disp_exp(input int r);
        int src;
        src = (m_state == M_SHOW) ? m_res : m_buf;
        case (r)
            0: return m_state;
            1: return m_err;
            2: return m_op;
            3: return m_a;
            4: return m_b;
            5: return 16;
            6: return src / 16;
            default: return src % 16;
        endcase
    endfunction

    task automatic press(input int k);
        @(posedge clk);
        #1 key_val = k[3:0];
        key_stb = 1'b1;
        @(posedge clk);
        #1 key_stb = 1'b0;
        key_val = 4'($urandom);
    endtask

    task automatic key(input int k);
        press(k);
        model_key(k);
    endtask

    task automatic check_disp(input string nm, input int r);
        rr = r[2:0];
        repeat (2) @(posedge clk);
        #1;
        probe($sformatf("%s.rr%0d", nm, r), 0, disp_exp(r));
    endtask

    task automatic check_regs(input string tag);
        probe({tag, ".A"}, 1, m_a);
        probe({tag, ".B"}, 2, m_b);
        probe({tag, ".OpCode"}, 3, m_op);
        probe({tag, ".err"}, 4, m_err);
        probe({tag, ".busy"}, 5, (m_state == M_ENTRY) ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        probe({tag, ".digit"}, 0, 16);
        probe({tag, ".A"}, 1, 0);
        probe({tag, ".B"}, 2, 0);
        probe({tag, ".OpCode"}, 3, 0);
        probe({tag, ".err"}, 4, 0);
        probe({tag, ".busy"}, 5, 0);
        probe({tag, ".alu_start"}, 6, 0);
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 8 && n_launch != m_launch; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // mode 0: done after dly, 1: F abort, 2: done and F together, 3: never done
    task automatic run_op(input string nm, input int mode, input int dly, input logic [7:0] r);
        launch_q.push_back({m_a[3:0], m_b[3:0], m_op[3:0]});
        m_launch++;
        press(K_D);
        wait_start();
        if (mode == 3) begin
            for (int i = 0; i < 400 && busy === 1'b1; i++) begin
                @(posedge clk);
                #1;
            end
            m_err = 1;
            m_state = M_IDLE;
        end else begin
            repeat (dly) @(posedge clk);
            #1;
            if (mode != 1) begin
                alu_done = 1'b1;
                alu_result = r;
            end
            if (mode != 0) begin
                key_val = 4'hF;
                key_stb = 1'b1;
            end
            @(posedge clk);
            #1 alu_done = 1'b0;
            key_stb = 1'b0;
            alu_result = 8'($urandom);
            if (mode == 1) m_state = M_IDLE;
            else begin
                m_res = int'(r);
                m_state = M_SHOW;
            end
        end
        if (mode != 1) probe({nm, ".busy_cycles"}, 7, (mode == 3) ? 256 : dly + 1);
        probe({nm, ".launches"}, 9, m_launch);
    endtask

    initial begin
        int k;
        model_reset();
        #12;
        check_reset_outputs("por");
        release_reset();
        check_disp("por", 0);

        key(10); key(1); key(2); key(K_E);
        check_regs("load_a12");
        check_disp("load_a12", 3);
        check_disp("load_a12", 0);

        key(11); key(2); key(0); key(K_E);
        check_regs("b20_err");
        key(12);
        check_regs("c_clears_err");
        check_disp("c_clears_err", 0);
        key(K_F);

        key(10); key(3); key(K_E);
        key(11); key(5); key(K_E);
        key(12); key(1); key(K_E);
        check_regs("load_351");
        run_op("exec_08", 0, 10, 8'h08);
        check_disp("exec_08", 6);
        check_disp("exec_08", 7);
        check_disp("exec_08", 0);
        @(posedge clk);
        #1 alu_done = 1'b1;
        alu_result = 8'h55;
        @(posedge clk);
        #1 alu_done = 1'b0;
        check_disp("done_in_show", 7);

        run_op("done_vs_f", 2, 5, 8'h3C);
        check_disp("done_vs_f", 0);
        check_disp("done_vs_f", 6);

        run_op("timeout", 3, 0, 8'h00);
        check_regs("timeout");
        check_disp("timeout", 0);

        key(10); key(7);
        assert_reset();
        check_reset_outputs("rst_entry");
        release_reset();
        key(K_E);
        check_regs("rst_entry_e");

        launch_q.push_back(12'h000);
        m_launch++;
        press(K_D);
        wait_start();
        repeat (3) @(posedge clk);
        assert_reset();
        release_reset();
        @(posedge clk);
        #1 alu_done = 1'b1;
        alu_result = 8'h77;
        @(posedge clk);
        #1 alu_done = 1'b0;
        check_regs("rst_wait");
        check_disp("rst_wait", 0);

        for (int it = 0; it < 80; it++) begin
            k = int'($urandom_range(0, 15));
            if (k == K_D && m_state != M_ENTRY) begin
                run_op($sformatf("rand%0d", it), int'($urandom_range(0, 2)),
                       int'($urandom_range(1, 25)), 8'($urandom));
            end else begin
                key(k);
            end
            check_disp($sformatf("rand%0d", it), int'($urandom_range(0, 7)));
            check_regs($sformatf("rand%0d", it));
        end

        probe("launch_queue_drained", 8, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low; no other clock or reset inputs.
REQ-002 CLK100MHZ  in  1  system clock; all state changes on its rising edge.
REQ-003 CPU_RESETN  in  1  asynchronous active-low reset.
REQ-004 key_val  in  4  decoded key code: 0-9 digits, A/B/C operand-select keys, D execute, E enter, F clear.
REQ-005 key_stb  in  1  one-cycle strobe qualifying key_val; synchronous to CLK100MHZ.
REQ-006 rr  in  3  display digit select from the seven-segment refresh counter.
REQ-007 alu_done  in  1  ALU completion, level-sampled each cycle.
REQ-008 alu_result  in  8  ALU result, valid while alu_done=1.
REQ-009 A, B, OpCode  out  4 each  registered operand/opcode values driving the ALU.
REQ-010 alu_start  out  1  one-cycle launch pulse.
REQ-011 busy  out  1  high in ENTRY, EXEC, WAIT.
REQ-012 err  out  1  sticky error flag.
REQ-013 digit_holder  out  5  display nibble; bit4=1 means blank.

Function
REQ-014 States SHALL be IDLE, ENTRY, EXEC, WAIT, SHOW; target register tgt in {A, B, OpCode}; 2-digit BCD buffer buf[7:0].
REQ-015 IDLE/SHOW: key A/B/C -> ENTRY, tgt set, buf=00, err=0; key D -> EXEC; key F -> IDLE, err=0; digits and E ignored.
REQ-016 ENTRY: digit d -> buf={buf[3:0],d}; A/B/C -> retarget, buf=00; F -> IDLE, no write; D ignored.
REQ-017 ENTRY, key E: v=buf[7:4]*10+buf[3:0]; v<=15 -> tgt<=v[3:0], err=0; v>15 -> tgt unchanged, err=1; then IDLE.
REQ-018 Target register SHALL update on the cycle after the E strobe; no other path writes A, B, OpCode.
REQ-019 EXEC: alu_start=1 exactly one cycle, then WAIT; timeout counter cleared.
REQ-020 WAIT: alu_done=1 -> capture alu_result into res, SHOW; key F -> IDLE, no capture; other keys dropped.
REQ-021 WAIT timeout: 255 cycles without alu_done -> err=1, IDLE; counter 8-bit, no wrap.
REQ-022 alu_done and key_stb in the same WAIT cycle: done SHALL win, key dropped; alu_done outside WAIT ignored.
REQ-023 Display, registered, one-cycle latency: rr 000 -> {2'b00,state[2:0]}; 001 -> {4'b0,err}; 010 -> OpCode; 011 -> A; 100 -> B; 101 -> blank 5'b10000; 110 -> res[7:4] in SHOW else buf[7:4]; 111 -> res[3:0] in SHOW else buf[3:0]; nibble values prefixed with bit4=0.

Reset
REQ-024 CPU_RESETN low SHALL force IDLE, A=B=OpCode=0, buf=00, res=0, alu_start=0, busy=0, err=0, digit_holder=5'b10000, counter=0, immediately and independent of the clock.
REQ-025 Reset during WAIT SHALL discard the pending operation; a late alu_done after release is ignored.

Structure
REQ-026 Shared package alu_ctrl_pkg SHALL hold key codes (KEY_A..KEY_F), state encoding, BLANK=5'b10000, TIMEOUT=255.
REQ-027 One sub-module, bcd2_to_bin: 8-bit two-digit BCD in, 7-bit binary out, combinational.

Verification
REQ-028 Keys A,1,2,E -> A=12, err=0, IDLE; rr=011 -> digit_holder=5'b01100.
REQ-029 Keys B,2,0,E -> err=1, B unchanged (0); then C -> err=0.
REQ-030 A=3,B=5,OpCode=1 loaded, key D -> alu_start one cycle; alu_done with result 8'h08 after 10 cycles -> SHOW; rr=110/111 -> 5'h00/5'h08.
REQ-031 Key D, alu_done never asserted -> err=1, IDLE after 255 WAIT cycles; alu_start pulsed once.
REQ-032 A,7 then CPU_RESETN low mid-ENTRY -> all outputs reset values; E after release -> A stays 0.
REQ-033 WAIT, key_stb(F) and alu_done same cycle -> SHOW with result captured, no abort.
